// File: rtl/vc_pkg.sv
// Shared types and constants for the value_checker result monitor.
// Contents: FSM state enum, mismatch counter width and saturation value.
package vc_pkg;

   localparam int unsigned VC_CNT_W   = 8;
   localparam int unsigned VC_CNT_MAX = 255;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_PASS   = 3'd3,
      ST_FAIL   = 3'd4
   } vc_state_t;

endpackage

// File: rtl/vc_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports: clk, rst_n (async active-low), clr (priority over en), en,
//        count (registered, holds at MAX).
module vc_sat_counter #(
   parameter int unsigned W   = 8,
   parameter int unsigned MAX = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != W'(MAX))) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/value_checker.sv
// Clocked self-checking monitor: after a settle window, requires MATCH_RUN
// consecutive valid exact matches of observed against a latched expected
// value within TIMEOUT check cycles, then reports a sticky PASS or FAIL.
// Ports: clk, rst_n (async active-low), start, expected, observed,
//        observed_valid in; busy, done (1-cycle), pass, fail, mismatch_cnt out.
module value_checker
   import vc_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned SETTLE    = 2,
   parameter int unsigned MATCH_RUN = 3,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WIDTH-1:0]    expected,
   input  logic [WIDTH-1:0]    observed,
   input  logic                observed_valid,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                fail,
   output logic [VC_CNT_W-1:0] mismatch_cnt
);

   localparam int unsigned SET_W = 4;
   localparam int unsigned RUN_W = 4;
   localparam int unsigned TMO_W = 8;

   vc_state_t          state_q, state_d;
   logic [WIDTH-1:0]   exp_q, exp_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic               busy_d, done_d, pass_d, fail_d;
   logic [RUN_W-1:0]   run_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic               run_clr, run_en, tmo_clr, tmo_en, mm_clr, mm_en;
   logic               sample_match;

   // Case equality so any unknown bit on the observed bus counts as a mismatch
   assign sample_match = (observed === exp_q);

   vc_sat_counter #(.W(VC_CNT_W), .MAX(VC_CNT_MAX)) u_mm_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (mm_clr),
      .en    (mm_en),
      .count (mismatch_cnt)
   );

   vc_sat_counter #(.W(RUN_W), .MAX((1 << RUN_W) - 1)) u_run_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (run_clr),
      .en    (run_en),
      .count (run_cnt)
   );

   vc_sat_counter #(.W(TMO_W), .MAX((1 << TMO_W) - 1)) u_tmo_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmo_clr),
      .en    (tmo_en),
      .count (tmo_cnt)
   );

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         exp_q    <= '0;
         settle_q <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail     <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         settle_q <= settle_d;
         busy     <= busy_d;
         done     <= done_d;
         pass     <= pass_d;
         fail     <= fail_d;
      end
   end

   // Next-state, counter controls and next output values
   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      settle_d = settle_q;
      done_d   = 1'b0;
      pass_d   = pass;
      fail_d   = fail;
      run_clr  = 1'b0;
      run_en   = 1'b0;
      tmo_clr  = 1'b0;
      tmo_en   = 1'b0;
      mm_clr   = 1'b0;
      mm_en    = 1'b0;

      case (state_q)
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (start) begin
               exp_d    = expected;
               pass_d   = 1'b0;
               fail_d   = 1'b0;
               mm_clr   = 1'b1;
               run_clr  = 1'b1;
               tmo_clr  = 1'b1;
               settle_d = SET_W'(SETTLE);
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            settle_d = settle_q - SET_W'(1);
            if (settle_q <= SET_W'(1)) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            tmo_en = 1'b1;
            if (observed_valid) begin
               if (sample_match) begin
                  run_en = 1'b1;
               end else begin
                  run_clr = 1'b1;
                  mm_en   = 1'b1;
               end
            end
            // Run completion on this sample wins over a simultaneous timeout
            if (observed_valid && sample_match &&
                (run_cnt == RUN_W'(MATCH_RUN - 1))) begin
               state_d = ST_PASS;
               pass_d  = 1'b1;
               done_d  = 1'b1;
            end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
               state_d = ST_FAIL;
               fail_d  = 1'b1;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
   end

endmodule

// File: tb/tb_value_checker.sv
module tb_value_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic [3:0] expected = 4'h0;
   logic [3:0] observed = 4'h0;
   logic       observed_valid = 1'b0;

   logic       busy, done, pass, fail;
   logic [7:0] mismatch_cnt;
   logic       busy2, done2, pass2, fail2;
   logic [7:0] mismatch_cnt2;

   value_checker dut (
      .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
      .observed(observed), .observed_valid(observed_valid),
      .busy(busy), .done(done), .pass(pass), .fail(fail),
      .mismatch_cnt(mismatch_cnt)
   );

   value_checker #(.TIMEOUT(255)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected),
      .observed(observed), .observed_valid(observed_valid),
      .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
      .mismatch_cnt(mismatch_cnt2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic p;
      logic f;
      int   mcnt;
      int   lat;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         start_cyc = 0;
   logic [3:0] obs_q[$];
   bit         vld_q[$];

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // Monitor: invariants every cycle, scoreboard pop on each done pulse
   always @(negedge clk) begin
      if (rst_n) begin
         check("pass_and_fail", int'(pass && fail), 0);
         check("done_while_busy", int'(done && busy), 0);
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", sb.size(), 1);
            end else begin
               mon_e = sb.pop_front();
               check("verdict_pass", int'(pass), int'(mon_e.p));
               check("verdict_fail", int'(fail), int'(mon_e.f));
               check("mismatch_cnt", int'(mismatch_cnt), mon_e.mcnt);
               check("done_latency", cyc - start_cyc, mon_e.lat);
            end
         end
      end
   end

   task automatic push_obs(input logic [3:0] o, input bit v, input int n);
      for (int i = 0; i < n; i++) begin
         obs_q.push_back(o);
         vld_q.push_back(v);
      end
   endtask

   // One check on the main instance; obs_q/vld_q supply CHECK-phase samples,
   // fill values are driven from the start cycle and after the queue drains.
   task automatic run_check(input logic [3:0] exp, input logic [3:0] fill_o,
                            input logic fill_v, input bit poke,
                            input logic ep, input logic ef,
                            input int em, input int el);
      exp_t e;
      e.p = ep; e.f = ef; e.mcnt = em; e.lat = el;
      @(negedge clk);
      start = 1'b1;
      expected = exp;
      observed = fill_o;
      observed_valid = fill_v;
      start_cyc = cyc;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("start_busy", int'(busy), 1);
      check("start_done", int'(done), 0);
      check("start_clr_pass", int'(pass), 0);
      check("start_clr_fail", int'(fail), 0);
      check("start_clr_mcnt", int'(mismatch_cnt), 0);
      if (poke) begin
         start = 1'b1;
         expected = ~exp;
      end
      @(negedge clk);
      start = 1'b0;
      expected = ~exp;
      for (int i = 0; i < 400 && sb.size() != 0; i++) begin
         @(negedge clk);
         if (obs_q.size() != 0) begin
            observed = obs_q.pop_front();
            observed_valid = vld_q.pop_front();
         end else begin
            observed = fill_o;
            observed_valid = fill_v;
         end
      end
      if (sb.size() != 0) begin
         check("done_wait_bound", sb.size(), 0);
         sb.delete();
      end
      obs_q.delete();
      vld_q.delete();
      observed_valid = 1'b0;
   endtask

   initial begin
      int s;

      // Reset state
      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass), 0);
      check("rst_fail", int'(fail), 0);
      check("rst_mcnt", int'(mismatch_cnt), 0);
      check("rst_mcnt2", int'(mismatch_cnt2), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic pass, with an ignored start while busy
      run_check(4'h5, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 6);

      // Uninitialised source
      run_check(4'h5, 4'bxxxx, 1'b1, 1'b0, 1'b0, 1'b1, 16, 19);

      // Broken run; settle-phase mismatches must be ignored
      push_obs(4'hA, 1'b1, 2);
      push_obs(4'h3, 1'b1, 1);
      push_obs(4'hA, 1'b1, 3);
      run_check(4'hA, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1, 9);

      // Gaps in valid
      push_obs(4'hA, 1'b1, 1);
      push_obs(4'h3, 1'b0, 1);
      push_obs(4'hA, 1'b1, 1);
      push_obs(4'h3, 1'b0, 2);
      push_obs(4'hA, 1'b1, 1);
      run_check(4'hA, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 0, 9);

      // Never valid: timeout with no mismatches counted
      run_check(4'hA, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 0, 19);

      // Run completes on the final CHECK cycle: PASS beats timeout
      push_obs(4'h0, 1'b1, 13);
      push_obs(4'h6, 1'b1, 3);
      run_check(4'h6, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 13, 19);

      // Run one sample short at timeout
      push_obs(4'h0, 1'b1, 14);
      run_check(4'h6, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 14, 19);

      // Reset mid-CHECK
      @(negedge clk);
      start = 1'b1;
      expected = 4'h5;
      observed = 4'h5;
      observed_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_pass", int'(pass), 0);
      check("midrst_fail", int'(fail), 0);
      check("midrst_mcnt", int'(mismatch_cnt), 0);
      repeat (2) begin
         @(negedge clk);
         check("inrst_done", int'(done), 0);
      end
      rst_n = 1'b1;
      observed_valid = 1'b0;
      run_check(4'h5, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 0, 6);

      // Saturation on the long-timeout instance
      @(negedge clk);
      start2 = 1'b1;
      expected = 4'h5;
      observed = 4'h0;
      observed_valid = 1'b1;
      s = cyc;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 400 && done2 !== 1'b1; i++) @(negedge clk);
      check("sat_done_seen", int'(done2), 1);
      check("sat_latency", cyc - s, 258);
      check("sat_fail", int'(fail2), 1);
      check("sat_pass", int'(pass2), 0);
      check("sat_mcnt", int'(mismatch_cnt2), 255);
      @(negedge clk);
      check("sat_mcnt_hold", int'(mismatch_cnt2), 255);
      check("sat_done_pulse", int'(done2), 0);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      check("sat_restart_mcnt", int'(mismatch_cnt2), 0);
      check("sat_restart_fail", int'(fail2), 0);
      check("sat_restart_busy", int'(busy2), 1);
      observed_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
